// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard scheduler.
//   REG_W        register-index width
//   FWD_*        operand-forwarding select encodings
//   stage_tag_t  destination tag carried by an in-flight instruction
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_EXALU  = 2'b01;
    localparam logic [1:0] FWD_MEMALU = 2'b10;
    localparam logic [1:0] FWD_MEMLD  = 2'b11;

    typedef struct packed {
        logic             wreg;
        logic             m2reg;
        logic [REG_W-1:0] rn;
    } stage_tag_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the ID stage / data memory and the hazard scheduler.
//   master : ID-stage decoder side, drives id_* and mem_ready, reads results
//   slave  : hazard scheduler, reads id_* and mem_ready, drives fwda/fwdb,
//            wpcir, ex_bubble, freeze and stall_cnt
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipeline_hazard_ctrl_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_need_rs;
    logic             id_need_rt;
    logic             id_wreg;
    logic             id_m2reg;
    logic [REG_W-1:0] id_rn;
    logic             mem_ready;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             wpcir;
    logic             ex_bubble;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_need_rs, id_need_rt,
               id_wreg, id_m2reg, id_rn, mem_ready,
        input  fwda, fwdb, wpcir, ex_bubble, freeze, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_need_rs, id_need_rt,
               id_wreg, id_m2reg, id_rn, mem_ready,
        output fwda, fwdb, wpcir, ex_bubble, freeze, stall_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Forwarding decision for one ID source operand.
//   i_src       source register index
//   i_need      operand is actually read by a real instruction
//   i_ex/i_mem  destination tags of the EX and MEM stage instructions
//   o_fwd       operand select (FWD_* encoding)
//   o_load_use  operand depends on a load still in EX (must stall)
// -----------------------------------------------------------------------------
module fwd_select
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic             i_need,
    input  stage_tag_t       i_ex,
    input  stage_tag_t       i_mem,
    output logic [1:0]       o_fwd,
    output logic             o_load_use
);

    logic w_ex_hit;
    logic w_mem_hit;

    // r0 is hardwired to zero, so a write to it must never be forwarded.
    assign w_ex_hit  = i_need && i_ex.wreg  && (i_ex.rn  != '0) && (i_ex.rn  == i_src);
    assign w_mem_hit = i_need && i_mem.wreg && (i_mem.rn != '0) && (i_mem.rn == i_src);

    always_comb begin
        o_fwd      = FWD_REG;
        o_load_use = 1'b0;
        // The younger EX result wins over MEM for the same register.
        if (w_ex_hit) begin
            if (i_ex.m2reg) begin
                o_load_use = 1'b1;
            end else begin
                o_fwd = FWD_EXALU;
            end
        end else if (w_mem_hit) begin
            o_fwd = i_mem.m2reg ? FWD_MEMLD : FWD_MEMALU;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard scheduler for the 5-stage pipeline. Shadows the EX/MEM destination
// tags, produces rs/rt forwarding selects, the load-use stall (wpcir low,
// bubble into ID/EX) and the global freeze while data memory is busy.
//   clk, rst_n  pipeline clock, asynchronous active-low reset
//   bus         slave modport of pipeline_hazard_ctrl_if
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_hazard_ctrl_if.slave        bus
);

    stage_tag_t       r_ex;
    stage_tag_t       r_mem;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [REG_W-1:0] w_src [2];
    logic [1:0]       w_need;
    logic [1:0]       w_fwd [2];
    logic [1:0]       w_load_use;
    logic             w_stall;
    logic             w_freeze;

    assign w_src[0]  = bus.id_rs;
    assign w_src[1]  = bus.id_rt;
    assign w_need[0] = bus.id_need_rs && bus.id_valid;
    assign w_need[1] = bus.id_need_rt && bus.id_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_select u_fwd_select (
                .i_src      (w_src[gi]),
                .i_need     (w_need[gi]),
                .i_ex       (r_ex),
                .i_mem      (r_mem),
                .o_fwd      (w_fwd[gi]),
                .o_load_use (w_load_use[gi])
            );
        end
    endgenerate

    assign w_stall  = bus.id_valid && (|w_load_use);
    assign w_freeze = !bus.mem_ready;

    assign bus.fwda      = w_fwd[0];
    assign bus.fwdb      = w_fwd[1];
    assign bus.freeze    = w_freeze;
    // Freeze dominates: while frozen nothing moves, so no bubble is inserted
    // and the stall is simply re-evaluated once memory completes.
    assign bus.ex_bubble = w_stall && !w_freeze;
    assign bus.wpcir     = !(w_stall || w_freeze);
    assign bus.stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_stall_cnt <= '0;
        end else if (!w_freeze) begin
            // A stalled instruction enters EX as a bubble (wreg cleared).
            r_ex.wreg  <= bus.id_wreg && bus.id_valid && !w_stall;
            r_ex.m2reg <= bus.id_m2reg;
            r_ex.rn    <= bus.id_rn;
            r_mem      <= r_ex;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int EXP_W = 2 + 2 + 1 + 1 + 1 + CNT_W;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [EXP_W-1:0] exp_q  [$];
    string            name_q [$];
    int               checks = 0;
    int               errors = 0;
    int               txn    = 0;

    // Drive one ID-stage cycle just after the clock edge and queue the
    // hand-computed response the monitor should see in this cycle.
    task automatic step(input string nm, input logic v,
                        input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic nrs, input logic nrt, input logic wr, input logic m2,
                        input logic [REG_W-1:0] rn, input logic mr,
                        input logic [1:0] efa, input logic [1:0] efb,
                        input logic ewp, input logic ebub, input int ecnt);
        logic [CNT_W-1:0] c;
        @(posedge clk);
        #1;
        bus.id_valid   = v;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_need_rs = nrs;
        bus.id_need_rt = nrt;
        bus.id_wreg    = wr;
        bus.id_m2reg   = m2;
        bus.id_rn      = rn;
        bus.mem_ready  = mr;
        c = CNT_W'(ecnt);
        exp_q.push_back({efa, efb, ewp, ebub, !mr, c});
        name_q.push_back(nm);
    endtask

    // Monitor: compares every presented response against the scoreboard.
    initial begin
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {bus.fwda, bus.fwdb, bus.wpcir, bus.ex_bubble, bus.freeze, bus.stall_cnt};
                checks++;
                txn++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got fwda=%b fwdb=%b wpcir=%b bubble=%b freeze=%b cnt=%0d, expected fwda=%b fwdb=%b wpcir=%b bubble=%b freeze=%b cnt=%0d",
                             nm, a[EXP_W-1 -: 2], a[EXP_W-3 -: 2], a[CNT_W+2], a[CNT_W+1], a[CNT_W], a[CNT_W-1:0],
                             e[EXP_W-1 -: 2], e[EXP_W-3 -: 2], e[CNT_W+2], e[CNT_W+1], e[CNT_W], e[CNT_W-1:0]);
                end else begin
                    $display("txn %0d %s ok: fwda=%b fwdb=%b wpcir=%b bubble=%b freeze=%b cnt=%0d",
                             txn, nm, a[EXP_W-1 -: 2], a[EXP_W-3 -: 2], a[CNT_W+2], a[CNT_W+1], a[CNT_W], a[CNT_W-1:0]);
                end
            end
        end
    end

    initial begin
        int sc;
        int rc;
        int wait_cyc;
        rst_n          = 1'b0;
        bus.id_valid   = 1'b1;
        bus.id_rs      = 5'd5;
        bus.id_rt      = 5'd5;
        bus.id_need_rs = 1'b1;
        bus.id_need_rt = 1'b1;
        bus.id_wreg    = 1'b1;
        bus.id_m2reg   = 1'b1;
        bus.id_rn      = 5'd5;
        bus.mem_ready  = 1'b1;

        // Reset held with every ID input active.
        step("rst_hold_a", 1, 5, 5, 1, 1, 1, 1, 5, 1, 2'b00, 2'b00, 1, 0, 0);
        step("rst_hold_b", 1, 5, 5, 1, 1, 1, 1, 5, 1, 2'b00, 2'b00, 1, 0, 0);
        @(negedge clk);
        #1;
        bus.id_valid = 1'b0;
        bus.id_wreg  = 1'b0;
        rst_n        = 1'b1;

        //    name           v rs rt nrs nrt wr m2 rn mr  fwda   fwdb  wp bub cnt
        step("release_idle", 1, 5, 5, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0, 0);
        step("add_r5",       1, 1, 2, 1, 1, 1, 0, 5, 1, 2'b00, 2'b00, 1, 0, 0);
        step("ex_fwd",       1, 5, 5, 1, 1, 1, 0, 6, 1, 2'b01, 2'b01, 1, 0, 0);
        step("mem_fwd",      1, 5, 0, 1, 0, 0, 0, 0, 1, 2'b10, 2'b00, 1, 0, 0);
        step("wb_none",      1, 5, 6, 1, 1, 0, 0, 0, 1, 2'b00, 2'b10, 1, 0, 0);
        step("lw_r8",        1, 1, 2, 1, 0, 1, 1, 8, 1, 2'b00, 2'b00, 1, 0, 0);
        step("lu_stall",     1, 8, 3, 1, 1, 1, 0, 9, 1, 2'b00, 2'b00, 0, 1, 0);
        step("lu_resolve",   1, 8, 3, 1, 1, 1, 0, 9, 1, 2'b11, 2'b00, 1, 0, 1);
        step("wr_r0",        1, 1, 2, 1, 1, 1, 1, 0, 1, 2'b00, 2'b00, 1, 0, 1);
        step("r0_consumer",  1, 0, 0, 1, 1, 1, 0, 3, 1, 2'b00, 2'b00, 1, 0, 1);
        step("need_gate",    1, 3, 3, 0, 0, 1, 0, 3, 1, 2'b00, 2'b00, 1, 0, 1);
        step("ex_priority",  1, 3, 3, 1, 1, 0, 0, 0, 1, 2'b01, 2'b01, 1, 0, 1);
        step("valid_gate",   0, 3, 3, 1, 1, 1, 1, 7, 1, 2'b00, 2'b00, 1, 0, 1);
        step("lw_r4",        1, 1, 2, 0, 0, 1, 1, 4, 1, 2'b00, 2'b00, 1, 0, 1);
        step("frz_lu_1",     1, 1, 4, 0, 1, 1, 0, 10, 0, 2'b00, 2'b00, 0, 0, 1);
        step("frz_lu_2",     1, 1, 4, 0, 1, 1, 0, 10, 0, 2'b00, 2'b00, 0, 0, 1);
        step("frz_lu_3",     1, 1, 4, 0, 1, 1, 0, 10, 0, 2'b00, 2'b00, 0, 0, 1);
        step("frz_drop",     1, 1, 4, 0, 1, 1, 0, 10, 1, 2'b00, 2'b00, 0, 1, 1);
        step("frz_resolve",  1, 1, 4, 0, 1, 1, 0, 10, 1, 2'b00, 2'b11, 1, 0, 2);
        step("frz_plain",    1, 10, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 2);
        step("frz_plain_go", 1, 10, 0, 1, 0, 0, 0, 0, 1, 2'b01, 2'b00, 1, 0, 2);

        // lw r8,0(r8) repeated: alternates one stall cycle and one resolved
        // cycle, so the counter climbs by one per pair and must pin at 15.
        step("sat_seed",     1, 8, 0, 1, 0, 1, 1, 8, 1, 2'b00, 2'b00, 1, 0, 2);
        for (int k = 0; k < 20; k++) begin
            sc = (2 + k > 15) ? 15 : 2 + k;
            rc = (3 + k > 15) ? 15 : 3 + k;
            step($sformatf("sat_stall_%0d", k),   1, 8, 0, 1, 0, 1, 1, 8, 1, 2'b00, 2'b00, 0, 1, sc);
            step($sformatf("sat_resolve_%0d", k), 1, 8, 0, 1, 0, 1, 1, 8, 1, 2'b11, 2'b00, 1, 0, rc);
        end

        // Reset asserted in the middle of a stall clears everything at once.
        step("pre_rst_stall",    1, 8, 0, 1, 0, 1, 1, 8, 1, 2'b00, 2'b00, 0, 1, 15);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        step("rst_mid",          1, 8, 0, 1, 0, 1, 1, 8, 1, 2'b00, 2'b00, 1, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst_stall",   1, 8, 0, 1, 0, 1, 1, 8, 1, 2'b00, 2'b00, 0, 1, 0);
        step("post_rst_resolve", 1, 8, 0, 1, 0, 1, 1, 8, 1, 2'b11, 2'b00, 1, 0, 1);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses never checked, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
